// File: rtl/seq_divider.sv
// seq_divider
//   Multicycle restoring divider: one quotient bit per clock on operand
//   magnitudes, signs reapplied when the result is registered.
//
//   clk       system clock, rising edge
//   reset     synchronous, active-high
//   start     request, accepted only in IDLE
//   issigned  1 = two's-complement divide, 0 = unsigned (sampled with start)
//   a, b      dividend / divisor (sampled with start)
//   busy      high in CALC and FINISH
//   done      one-cycle pulse in FINISH
//   q, rem    quotient / remainder, held until the next result is written
//   divzero   captured divisor was zero, cleared on the next accepted start
//
//   state  | meaning
//   IDLE   | waiting for start
//   CALC   | WIDTH shift-subtract iterations
//   FINISH | result registered, done pulse
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             issigned,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] rem,
  output logic             divzero
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FINISH
  } state_t;

  state_t state, state_nxt;

  logic             load, iter, last;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] dvd;   // dividend magnitude, quotient shifts in at the bottom
  logic [WIDTH-1:0] dvs;   // divisor magnitude
  logic [WIDTH-1:0] p;     // partial remainder, always < dvs so WIDTH bits suffice
  logic             neg_q, neg_r;

  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   p_shift;
  logic [WIDTH-1:0] p_sub, p_iter, dvd_iter;
  logic             q_bit;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    iter      = 1'b0;
    last      = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = (b == '0) ? S_FINISH : S_CALC;
        end
      end
      S_CALC: begin
        busy = 1'b1;
        iter = 1'b1;
        if (cnt == CNT_LAST) begin
          last      = 1'b1;
          state_nxt = S_FINISH;
        end
      end
      S_FINISH: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    a_mag    = (issigned && a[WIDTH-1]) ? -a : a;
    b_mag    = (issigned && b[WIDTH-1]) ? -b : b;
    p_shift  = {p, dvd[WIDTH-1]};
    q_bit    = (p_shift >= {1'b0, dvs});
    // the difference is below dvs whenever it is taken, so WIDTH bits are exact
    p_sub    = p_shift[WIDTH-1:0] - dvs;
    p_iter   = q_bit ? p_sub : p_shift[WIDTH-1:0];
    dvd_iter = {dvd[WIDTH-2:0], q_bit};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      dvd     <= '0;
      dvs     <= '0;
      p       <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      q       <= '0;
      rem     <= '0;
      divzero <= 1'b0;
    end else begin
      if (load) begin
        cnt     <= '0;
        dvd     <= a_mag;
        dvs     <= b_mag;
        p       <= '0;
        neg_q   <= issigned & (a[WIDTH-1] ^ b[WIDTH-1]);
        neg_r   <= issigned & a[WIDTH-1];
        divzero <= 1'b0;
        if (b == '0) begin
          // divide by zero skips CALC, so the result is written here
          q       <= '1;
          rem     <= a;
          divzero <= 1'b1;
        end
      end
      if (iter) begin
        cnt <= cnt + CW'(1);
        dvd <= dvd_iter;
        p   <= p_iter;
        if (last) begin
          q   <= neg_q ? -dvd_iter : dvd_iter;
          rem <= neg_r ? -p_iter : p_iter;
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
module tb_seq_divider;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset, start, issigned;
  logic [W-1:0] a, b, q, rem;
  logic         busy, done, divzero;

  always #5 clk = ~clk;

  seq_divider #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .issigned(issigned),
    .a(a), .b(b), .busy(busy), .done(done), .q(q), .rem(rem), .divzero(divzero)
  );

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] rem;
    logic         dz;
  } exp_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         s;
    logic [W-1:0] q;
    logic [W-1:0] rem;
    logic         dz;
    int           lat;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[11];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    exp_t r;
    logic signed [W-1:0] sx, sy;
    sx = x;
    sy = y;
    if (y == '0) begin
      r.q = '1; r.rem = x; r.dz = 1'b1;
    end else if (s) begin
      r.q = sx / sy; r.rem = sx % sy; r.dz = 1'b0;
    end else begin
      r.q = x / y; r.rem = x % y; r.dz = 1'b0;
    end
    return r;
  endfunction

  // Waits for done after the accepting edge; lat counts cycles from acceptance.
  task automatic wait_done(input string name, input int elat, output int lat);
    int busy_cnt;
    exp_t e;
    lat = 0;
    busy_cnt = 0;
    while (lat < 200) begin
      @(negedge clk);
      lat++;
      if (busy) busy_cnt++;
      if (done) break;
    end
    chk({name, ".done"}, W'(done), W'(1));
    if (done) begin
      chk({name, ".lat"}, W'(lat), W'(elat));
      chk({name, ".busy"}, W'(busy_cnt), W'(elat));
      if (sb.size() == 0) begin
        chk({name, ".sb_empty"}, W'(sb.size()), W'(1));
      end else begin
        e = sb.pop_front();
        chk({name, ".q"}, q, e.q);
        chk({name, ".rem"}, rem, e.rem);
        chk({name, ".divzero"}, W'(divzero), W'(e.dz));
      end
    end
  endtask

  task automatic run_op(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                        input logic ts, input exp_t e, input int elat);
    int lat;
    sb.push_back(e);
    @(negedge clk);
    a = ta; b = tb_; issigned = ts; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = $urandom; b = $urandom; issigned = 1'($urandom_range(0, 1));
    wait_done(name, elat, lat);
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    exp_t e;
    int   lat, dcnt;
    logic [W-1:0] ra, rb;
    logic rs;

    vecs[0]  = '{32'd100,      32'd7,        1'b0, 32'd14,       32'd2,        1'b0, 33};
    vecs[1]  = '{32'hFFFFFFF9, 32'd2,        1'b1, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 33};
    vecs[2]  = '{32'd7,        32'hFFFFFFFE, 1'b1, 32'hFFFFFFFD, 32'd1,        1'b0, 33};
    vecs[3]  = '{32'd5,        32'd0,        1'b0, 32'hFFFFFFFF, 32'd5,        1'b1, 1};
    vecs[4]  = '{32'd9,        32'd3,        1'b0, 32'd3,        32'd0,        1'b0, 33};
    vecs[5]  = '{32'd5,        32'd0,        1'b1, 32'hFFFFFFFF, 32'd5,        1'b1, 1};
    vecs[6]  = '{32'hFFFFFFF0, 32'd0,        1'b1, 32'hFFFFFFFF, 32'hFFFFFFF0, 1'b1, 1};
    vecs[7]  = '{32'd9,        32'd3,        1'b1, 32'd3,        32'd0,        1'b0, 33};
    vecs[8]  = '{32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 32'd0,        1'b0, 33};
    vecs[9]  = '{32'hFFFFFFFF, 32'd1,        1'b0, 32'hFFFFFFFF, 32'd0,        1'b0, 33};
    vecs[10] = '{32'd3,        32'd10,       1'b0, 32'd0,        32'd3,        1'b0, 33};

    reset = 1'b1; start = 1'b0; issigned = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst.busy", W'(busy), W'(0));
    chk("rst.done", W'(done), W'(0));
    chk("rst.q", q, '0);
    chk("rst.rem", rem, '0);
    chk("rst.divzero", W'(divzero), W'(0));

    for (int i = 0; i < 11; i++) begin
      e = '{vecs[i].q, vecs[i].rem, vecs[i].dz};
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].s, e, vecs[i].lat);
    end

    // second start mid-operation is ignored, inputs changed after acceptance
    sb.push_back('{32'd10, 32'd0, 1'b0});
    @(negedge clk);
    a = 32'd50; b = 32'd5; issigned = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0;
    dcnt = 0;
    while (lat < 200) begin
      @(negedge clk);
      lat++;
      if (done) break;
      if (lat == 9) begin a = 32'd1; b = 32'd1; start = 1'b1; end
      if (lat == 10) begin a = 32'd77; b = 32'd3; start = 1'b0; end
    end
    chk("hs.done", W'(done), W'(1));
    chk("hs.lat", W'(lat), W'(33));
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("hs.q", q, e.q);
      chk("hs.rem", rem, e.rem);
    end
    repeat (5) @(negedge clk);
    chk("hs.hold_q", q, 32'd10);
    chk("hs.hold_rem", rem, 32'd0);
    chk("hs.idle_busy", W'(busy), W'(0));

    // reset in the middle of CALC discards the operation
    @(negedge clk);
    a = 32'd100; b = 32'd7; issigned = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (14) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("midrst.busy", W'(busy), W'(0));
    chk("midrst.done", W'(done), W'(0));
    chk("midrst.q", q, '0);
    chk("midrst.rem", rem, '0);
    dcnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    chk("midrst.no_done", W'(dcnt), W'(0));
    run_op("after_rst", 32'd100, 32'd7, 1'b0, '{32'd14, 32'd2, 1'b0}, 33);

    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      rb = (i % 4 == 0) ? W'($urandom_range(1, 300)) : W'($urandom);
      rs = 1'($urandom_range(0, 1));
      if (rb == '0) rb = 32'd1;
      if (rs && ra == 32'h80000000 && rb == 32'hFFFFFFFF) rb = 32'd1;
      e = model(ra, rb, rs);
      run_op($sformatf("rnd%0d", i), ra, rb, rs, e, 33);
      chk($sformatf("rnd%0d.inv", i), q * rb + rem, ra);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
